// File: rtl/tdm_demux_sixteen.sv
// tdm_demux_sixteen: 1-to-16 TDM demultiplexer that steers serial slot bits into a
// one-hot output and assembles them into frames presented with a ready strobe.
module tdm_demux_sixteen #(
    parameter int N  = 16,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          d,
    input  logic          v,
    input  logic          start,
    output logic [SW-1:0] s,
    output logic [N-1:0]  y,
    output logic [N-1:0]  q,
    output logic          rdy,
    output logic          busy,
    output logic          err
);
    typedef enum logic {IDLE, RECV} state_t;
    state_t        state, state_n;
    logic [SW-1:0] s_n;
    logic [N-1:0]  shadow, shadow_n, y_n, q_n;
    logic          rdy_n, err_n;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            s      <= '0;
            shadow <= '0;
            y      <= '0;
            q      <= '0;
            rdy    <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            s      <= s_n;
            shadow <= shadow_n;
            y      <= y_n;
            q      <= q_n;
            rdy    <= rdy_n;
            err    <= err_n;
        end
    end
    // A qualified start always restarts at slot 0; mid-frame it also flags the abort.
    always_comb begin
        state_n  = state;
        s_n      = s;
        shadow_n = shadow;
        y_n      = '0;
        q_n      = q;
        rdy_n    = 1'b0;
        err_n    = 1'b0;
        if (v && start) begin
            shadow_n = N'(d);
            y_n      = N'(d);
            s_n      = SW'(1);
            state_n  = RECV;
            err_n    = (state == RECV);
        end else if (v && state == RECV) begin
            shadow_n[s] = d;
            y_n[s]      = d;
            s_n         = s + SW'(1);
            if (s == SW'(N - 1)) begin
                q_n     = shadow_n;
                rdy_n   = 1'b1;
                state_n = IDLE;
            end
        end
    end
    assign busy = (state == RECV);
endmodule

// File: tb/tb_tdm_demux_sixteen.sv
// tb_tdm_demux_sixteen: directed frames with a queue-based scoreboard; a monitor checks
// every rdy/err strobe against the expected frame value and cycle.
module tb_tdm_demux_sixteen;
    logic        clk = 1'b0, rstn = 1'b0, d = 1'b0, v = 1'b0, start = 1'b0;
    logic [3:0]  s;
    logic [15:0] y, q;
    logic        rdy, busy, err;
    int          compared = 0, mismatched = 0, cyc = 0;
    logic [15:0] exp_q[$];
    int          exp_c[$], exp_e[$];

    tdm_demux_sixteen dut (.clk(clk), .rstn(rstn), .d(d), .v(v), .start(start),
                           .s(s), .y(y), .q(q), .rdy(rdy), .busy(busy), .err(err));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (rstn) begin
        if (rdy) begin
            if (exp_q.size() == 0) chk("unexpected_rdy", 32'(q), 32'hDEAD);
            else begin
                chk("frame_q", 32'(q), 32'(exp_q.pop_front()));
                chk("rdy_cycle", 32'(cyc), 32'(exp_c.pop_front()));
            end
            chk("rdy_err_excl", 32'(err), 0);
        end
        if (err) begin
            if (exp_e.size() == 0) chk("unexpected_err", 1, 0);
            else chk("err_cycle", 32'(cyc), 32'(exp_e.pop_front()));
        end
    end

    task automatic send(input logic dd, input logic vv, input logic ss);
        d = dd; v = vv; start = ss;
        @(posedge clk); #1;
    endtask

    task automatic frame(input logic [15:0] f, input int st_a, input int st_b, input int extra);
        int c0;
        send(f[0], 1, 1);
        c0 = cyc;
        exp_q.push_back(f);
        exp_c.push_back(c0 + 15 + extra);
        for (int i = 1; i < 16; i++) begin
            send(f[i], 1, 0);
            if (i == st_a || i == st_b)
                repeat (3) begin
                    send(0, 0, 0);
                    chk("stall_s", 32'(s), 32'(i + 1));
                    chk("stall_y", 32'(y), 0);
                end
        end
    endtask

    initial begin
        #2;
        chk("rst_s", 32'(s), 0);
        chk("rst_q", 32'(q), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        send(1, 1, 1);
        repeat (4) send(1, 1, 0);
        chk("pre_rst_s", 32'(s), 5);
        rstn = 1'b0;
        #2;
        chk("mid_rst_s", 32'(s), 0);
        chk("mid_rst_q", 32'(q), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_y", 32'(y), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        // Single frame; busy must fall together with rdy.
        frame(16'hA5C3, -1, -1, 0);
        chk("busy_fall", 32'(busy), 0);
        chk("rdy_pulse", 32'(rdy), 1);
        send(0, 0, 0);
        chk("rdy_single", 32'(rdy), 0);
        frame(16'hA5C3, 4, 11, 6);
        send(0, 0, 0);
        // Abort: 7 bits of 0xFFFF, then restart with 0x1234.
        send(1, 1, 1);
        repeat (6) send(1, 1, 0);
        exp_e.push_back(cyc + 1);
        frame(16'h1234, -1, -1, 0);
        send(0, 0, 0);
        frame(16'h0001, -1, -1, 0);
        frame(16'h8000, -1, -1, 0);
        send(0, 0, 0);
        // Demux output check inside a 0x0200 frame.
        exp_q.push_back(16'h0200);
        send(0, 1, 1);
        exp_c.push_back(cyc + 16);
        for (int i = 1; i < 16; i++) begin
            send((i == 9), 1, 0);
            if (i == 9) chk("y_slot9", 32'(y), 32'h0200);
            if (i == 10) begin
                chk("y_d0", 32'(y), 0);
                send(1, 0, 0);
                chk("y_v0", 32'(y), 0);
                chk("y_v0_s", 32'(s), 11);
            end
        end
        repeat (3) send(0, 0, 0);
        chk("pending_rdy", 32'(exp_q.size()), 0);
        chk("pending_err", 32'(exp_e.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
